// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: control/redirect inputs from the pipeline, PC and IF/ID outputs back.
// The fetch unit connects through the slave modport; the pipeline/environment through master.
interface pc_fetch_unit_if #(
  parameter int N_BITS = 32
);
  logic              stall_i;
  logic              branch_taken_i;
  logic [N_BITS-1:0] branch_target_i;
  logic              jump_i;
  logic [N_BITS-1:0] jump_target_i;
  logic [N_BITS-1:0] pc_plus_step_i;
  logic [N_BITS-1:0] pc_o;
  logic [N_BITS-1:0] step_o;
  logic [N_BITS-1:0] if_pc_plus_step_o;
  logic              if_valid_o;
  logic              redirect_o;
  logic              misalign_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i,
    output jump_i, jump_target_i, pc_plus_step_i,
    input  pc_o, step_o, if_pc_plus_step_o, if_valid_o, redirect_o, misalign_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i,
    input  jump_i, jump_target_i, pc_plus_step_i,
    output pc_o, step_o, if_pc_plus_step_o, if_valid_o, redirect_o, misalign_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the MIPS fetch path.
// Holds the PC, feeds the external PC+step adder (pc_o -> data_0_i, step_o -> data_1_i),
// selects the next PC (jump > branch > stall > sequential) and registers the IF/ID PC+step.
// Optional feature macro: PC_MISALIGN_CHECK_EN (misaligned redirect targets trap to EXC_VECTOR;
// when undefined, target bits [1:0] are cleared and misalign_o is tied 0).
module pc_fetch_unit #(
  parameter int                N_BITS   = 32,
  parameter logic [N_BITS-1:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned       PC_STEP  = 4
`ifdef PC_MISALIGN_CHECK_EN
  , parameter logic [N_BITS-1:0] EXC_VECTOR = 32'h8000_0180
`endif
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [N_BITS-1:0] r_pc;
  logic [N_BITS-1:0] r_if_pc;
  logic              r_if_valid;
  logic              r_redirect;

  logic [N_BITS-1:0] w_pc_next;
  logic [N_BITS-1:0] w_if_pc_next;
  logic              w_if_valid_next;
  logic              w_redirect_next;
  logic              w_misalign_next;

  logic              w_redirect_req;
  logic [N_BITS-1:0] w_target_sel;
  logic              w_target_misaligned;

  // Redirect request and target selection; jump outranks branch.
  assign w_redirect_req      = bus.jump_i | bus.branch_taken_i;
  assign w_target_sel        = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
  assign w_target_misaligned = (w_target_sel[1:0] != 2'b00);

  // State register; reset forces BOOT regardless of any other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: BOOT is a single-cycle settle state, RUN is terminal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  // Output/datapath next-value logic for PC, IF/ID slot and the redirect/misalign pulses.
  always_comb begin
    w_pc_next       = r_pc;
    w_if_pc_next    = r_if_pc;
    w_if_valid_next = r_if_valid;
    w_redirect_next = 1'b0;
    w_misalign_next = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Inputs are ignored while the PC settles at RESET_PC.
        w_if_valid_next = 1'b0;
      end
      ST_RUN: begin
        if (w_redirect_req) begin
          // Redirect discards the current fetch (even a stalled one) and inserts a bubble.
          w_if_valid_next = 1'b0;
          w_redirect_next = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
          if (w_target_misaligned) begin
            w_pc_next       = EXC_VECTOR;
            w_misalign_next = 1'b1;
          end else begin
            w_pc_next = w_target_sel;
          end
`else
          w_pc_next = w_target_sel & ~N_BITS'(3);
`endif
        end else if (bus.stall_i) begin
          w_pc_next       = r_pc;
          w_if_pc_next    = r_if_pc;
          w_if_valid_next = r_if_valid;
        end else begin
          // Sequential: wrap-around is whatever the external adder produces.
          w_pc_next       = bus.pc_plus_step_i;
          w_if_pc_next    = bus.pc_plus_step_i;
          w_if_valid_next = 1'b1;
        end
      end
      default: begin
        w_pc_next       = RESET_PC;
        w_if_valid_next = 1'b0;
      end
    endcase
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_valid <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_if_pc    <= w_if_pc_next;
      r_if_valid <= w_if_valid_next;
      r_redirect <= w_redirect_next;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic r_misalign;

  // Misaligned-target pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_next;
    end
  end

  assign bus.misalign_o = r_misalign;
`else
  logic w_misalign_unused;
  assign w_misalign_unused = w_misalign_next | w_target_misaligned;
  assign bus.misalign_o    = 1'b0;
`endif

  assign bus.pc_o              = r_pc;
  assign bus.step_o            = N_BITS'(PC_STEP);
  assign bus.if_pc_plus_step_o = r_if_pc;
  assign bus.if_valid_o        = r_if_valid;
  assign bus.redirect_o        = r_redirect;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each step drives inputs, pushes the expected
// post-edge outputs to a scoreboard queue, then pops and compares after the edge.
module tb_pc_fetch_unit;

  logic clk;
  logic reset;

  pc_fetch_unit_if #(.N_BITS(32)) bus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External PC-increment adder.
  assign bus.pc_plus_step_i = bus.pc_o + bus.step_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic        valid;
    logic        redirect;
    logic        misalign;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic [31:0] E_MIS_BR_PC   = 32'h8000_0180;
  localparam logic [31:0] E_MIS_BR_NEXT = 32'h8000_0184;
  localparam logic        E_MIS         = 1'b1;
  localparam logic [31:0] E_MIS_J_PC    = 32'h8000_0180;
`else
  localparam logic [31:0] E_MIS_BR_PC   = 32'h0040_0100;
  localparam logic [31:0] E_MIS_BR_NEXT = 32'h0040_0104;
  localparam logic        E_MIS         = 1'b0;
  localparam logic [31:0] E_MIS_J_PC    = 32'h0040_0200;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                      input logic e_v, input logic e_r, input logic e_m);
    exp_t e;
    exp_t got;
    reset               = rst;
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = bt;
    bus.jump_i          = j;
    bus.jump_target_i   = jt;
    e.tag = tag; e.pc = e_pc; e.if_pc = e_ifpc;
    e.valid = e_v; e.redirect = e_r; e.misalign = e_m;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".pc"},       bus.pc_o,                     got.pc);
    chk({got.tag, ".if_pc"},    bus.if_pc_plus_step_o,        got.if_pc);
    chk({got.tag, ".valid"},    32'(bus.if_valid_o),          32'(got.valid));
    chk({got.tag, ".redirect"}, 32'(bus.redirect_o),          32'(got.redirect));
    chk({got.tag, ".misalign"}, 32'(bus.misalign_o),          32'(got.misalign));
    chk({got.tag, ".step"},     bus.step_o,                   32'd4);
    $display("step %-12s pc=%h if_pc=%h valid=%b redirect=%b misalign=%b",
             got.tag, bus.pc_o, bus.if_pc_plus_step_o, bus.if_valid_o,
             bus.redirect_o, bus.misalign_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held three cycles.
    step("rst0", 1, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("rst2", 1, 1, 1, 32'h0040_0100, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    // BOOT, then first RUN edge.
    step("boot", 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("run1", 0, 0, 0, 0, 0, 0, 32'h0040_0004, 32'h0040_0004, 1, 0, 0);
    step("run2", 0, 0, 0, 0, 0, 0, 32'h0040_0008, 32'h0040_0008, 1, 0, 0);
    step("run3", 0, 0, 0, 0, 0, 0, 32'h0040_000C, 32'h0040_000C, 1, 0, 0);
    step("run4", 0, 0, 0, 0, 0, 0, 32'h0040_0010, 32'h0040_0010, 1, 0, 0);
    step("run5", 0, 0, 0, 0, 0, 0, 32'h0040_0014, 32'h0040_0014, 1, 0, 0);
    // Stall two cycles.
    step("stall1", 0, 1, 0, 0, 0, 0, 32'h0040_0014, 32'h0040_0014, 1, 0, 0);
    step("stall2", 0, 1, 0, 0, 0, 0, 32'h0040_0014, 32'h0040_0014, 1, 0, 0);
    step("resume", 0, 0, 0, 0, 0, 0, 32'h0040_0018, 32'h0040_0018, 1, 0, 0);
    // Jump and branch together: jump wins, single pulse.
    step("jmp_br", 0, 0, 1, 32'h0040_0100, 1, 32'h0040_0200, 32'h0040_0200, 32'h0040_0018, 0, 1, 0);
    step("after_jb", 0, 0, 0, 0, 0, 0, 32'h0040_0204, 32'h0040_0204, 1, 0, 0);
    // Branch overrides stall.
    step("stall_br", 0, 1, 1, 32'h0040_0040, 0, 0, 32'h0040_0040, 32'h0040_0204, 0, 1, 0);
    step("after_sb", 0, 0, 0, 0, 0, 0, 32'h0040_0044, 32'h0040_0044, 1, 0, 0);
    // Back-to-back redirects.
    step("b2b_br", 0, 0, 1, 32'h0040_0080, 0, 0, 32'h0040_0080, 32'h0040_0044, 0, 1, 0);
    step("b2b_jmp", 0, 0, 0, 0, 1, 32'h0040_0300, 32'h0040_0300, 32'h0040_0044, 0, 1, 0);
    step("after_b2b", 0, 0, 0, 0, 0, 0, 32'h0040_0304, 32'h0040_0304, 1, 0, 0);
    // Wrap-around through the adder.
    step("jmp_top", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0040_0304, 0, 1, 0);
    step("wrap0", 0, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 0, 0);
    step("wrap1", 0, 0, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_0004, 1, 0, 0);
    // Misaligned branch and jump targets.
    step("mis_br", 0, 0, 1, 32'h0040_0102, 0, 0, E_MIS_BR_PC, 32'h0000_0004, 0, 1, E_MIS);
    step("after_mis", 0, 0, 0, 0, 0, 0, E_MIS_BR_NEXT, E_MIS_BR_NEXT, 1, 0, 0);
    step("mis_jmp", 0, 0, 0, 0, 1, 32'h0040_0203, E_MIS_J_PC, E_MIS_BR_NEXT, 0, 1, E_MIS);
    // Reset during a stalled redirect, then BOOT ignores a pending branch.
    step("rst_mid", 1, 1, 1, 32'h0040_0500, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("boot2", 0, 1, 1, 32'h0040_0500, 0, 0, 32'h0040_0000, 0, 0, 0, 0);
    step("run_again", 0, 0, 0, 0, 0, 0, 32'h0040_0004, 32'h0040_0004, 1, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
